// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port DataMemory.
// It runs one memory transaction at a time, always as IDLE -> ACCESS -> DONE.
// Requester 0 is the CPU load/store path. Requester 1 is the debug/DMA loader.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    // requester 1
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    // DataMemory side
    output logic              mem_memwrite,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    // Word-index limit, sized to match the word-index slice of an address.
    localparam logic [ADDR_W-3:0] WordLimit = (ADDR_W-2)'(MEM_WORDS);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              cmd_id_q, cmd_id_d;
    logic              cmd_err_q, cmd_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic              done;

    // Round-robin pick. On a tie, the requester that was not granted last time wins.
    always_comb begin
        gnt_valid = r0_req | r1_req;
        if (r0_req && r1_req) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = r1_req;
        end
        sel_we    = gnt_id ? r1_we    : r0_we;
        sel_addr  = gnt_id ? r1_addr  : r0_addr;
        sel_wdata = gnt_id ? r1_wdata : r0_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[ADDR_W-1:2] >= WordLimit);
    end

    // Next-state logic. The command registers hold their value unless a grant latches them.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_id_d     = cmd_id_q;
        cmd_err_d    = cmd_err_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    cmd_we_d     = sel_we;
                    cmd_addr_d   = sel_addr;
                    cmd_wdata_d  = sel_wdata;
                    cmd_id_d     = gnt_id;
                    cmd_err_d    = sel_err;
                    last_grant_d = gnt_id;
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                // Writes and rejected accesses report zero read data.
                rdata_d = (cmd_we_q || cmd_err_q) ? '0 : mem_readdata;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset. Reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_id_q     <= 1'b0;
            cmd_err_q    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_id_q     <= cmd_id_d;
            cmd_err_q    <= cmd_err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory drive and per-requester responses. Responses are nonzero only in the owner's DONE cycle.
    always_comb begin
        busy          = (state_q != StIdle);
        // Gating with rst keeps a write from landing when reset hits during ACCESS.
        mem_memwrite  = (state_q == StAccess) & cmd_we_q & ~cmd_err_q & ~rst;
        mem_endereco  = cmd_addr_q;
        mem_writedata = cmd_wdata_q;
        done          = (state_q == StDone);
        r0_ack        = done & ~cmd_id_q;
        r1_ack        = done & cmd_id_q;
        r0_err        = r0_ack & cmd_err_q;
        r1_err        = r1_ack & cmd_err_q;
        r0_rdata      = r0_ack ? rdata_q : '0;
        r1_rdata      = r1_ack ? rdata_q : '0;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter/sequencer in front of the single-port DataMemory; one memory transaction at a time.
- Requester 0 is the CPU load/store path; requester 1 is the debug/DMA loader.
- Drives DataMemory's memwrite/endereco/writedata and captures readdata. Each access runs a fixed 3-state sequence with an ack/err response.

Parameters:
- ADDR_W, 32, byte-address width on all address ports.
- DATA_W, 32, data word width.
- MEM_WORDS, 64, number of 32-bit words in DataMemory; used for the range check.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- r0_req  input  1  requester 0 access request (level)
- r0_we  input  1  1=write, 0=read
- r0_addr  input  ADDR_W  byte address
- r0_wdata  input  DATA_W  write data
- r0_ack  output  1  one-cycle completion pulse
- r0_err  output  1  error flag, valid with r0_ack
- r0_rdata  output  DATA_W  read data, valid with r0_ack
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same as requester 0, for requester 1
- mem_memwrite  output  1  to DataMemory memwrite
- mem_endereco  output  ADDR_W  to DataMemory endereco
- mem_writedata  output  DATA_W  to DataMemory writedata
- mem_readdata  input  DATA_W  from DataMemory readdata (combinational read)
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst high at an edge), all registered outputs 0:
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - cmd registers cleared, so mem_endereco=0 and mem_writedata=0.
  - r0/r1 ack, err and rdata all 0.
- State machine:
  - IDLE: sample reqs. If none, stay. If one, grant it. If both, grant the requester that is not last_grant.
  - On grant, latch the granted we/addr/wdata into cmd_*, set cmd_id and set last_grant=cmd_id, then go to ACCESS.
  - Error check at latch time: cmd_err = (addr[1:0]!=0) or (addr[ADDR_W-1:2] >= MEM_WORDS).
  - ACCESS (1 cycle): mem_endereco=cmd_addr and mem_writedata=cmd_wdata, both driven from registers.
  - mem_memwrite = (state==ACCESS) & cmd_we & ~cmd_err & ~rst; combinational and gated by rst.
  - At the ACCESS edge, capture rdata = (cmd_we|cmd_err) ? 0 : mem_readdata, then go to DONE.
  - DONE (1 cycle): assert ack of cmd_id with err=cmd_err and rdata=captured value; the other requester's outputs stay 0. Then go to IDLE.
- ack, err and rdata are 0 in every cycle other than the owner's DONE cycle.
- Latency: req high in IDLE cycle N → memory access in cycle N+1 → ack in cycle N+2. Minimum 3 cycles per transaction, back to back.
- Handshake: req must be held with stable we/addr/wdata until ack.
  - Req is sampled only in IDLE; changes in ACCESS/DONE are ignored.
  - Req still high in the IDLE after ack is a new transaction.
- Fairness: with both reqs continuously high, grants alternate 0,1,0,1…; no requester waits more than one transaction.
- An erroring request still takes the full ACCESS/DONE sequence (fixed latency) with no memory write.
- Reset mid-operation: rst in ACCESS suppresses mem_memwrite that cycle (no write lands); the pending transaction is dropped with no ack.
- Cmd registers hold their last value in IDLE; mem_memwrite is 0 outside ACCESS.

Test Plan:
- Reset, then r0 writes 0xDEADBEEF to 0x04, then reads 0x04:
  - Write: r0_ack in cycle 2 after req, memwrite high exactly one cycle with endereco=0x04.
  - Read: r0_rdata=0xDEADBEEF with r0_ack, r0_err=0.
- r0 and r1 both request in the same cycle after reset (r0 write 0xCAFEBABE@0x08, r1 read 0x08):
  - r0 granted first (ack at +2); r1 acks at +5 with rdata=0xCAFEBABE.
- Both reqs held high for 6 transactions → ack order 0,1,0,1,0,1, one ack every 3 cycles, never both acks in the same cycle.
- Error cases, r1 only:
  - r1 write to 0x06 (misaligned) → r1_ack with r1_err=1, memwrite never high, and a later read of 0x04 is unchanged.
  - r1 read of 0x100 (word 64, out of range) → err=1, rdata=0.
- Reset asserted during ACCESS of an r0 write 0x12345678@0x0C:
  - mem_memwrite stays 0, no r0_ack, busy=0 next cycle.
  - A subsequent read of 0x0C returns the prior content.
- r1 alone after reset → granted immediately (no idle wait), r1_ack at +2, r0 outputs remain 0 throughout.
